// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bus bundles for the unified memory port arbiter.
// Both interfaces carry the address and data widths as parameters.
interface mem_req_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata
    );
endinterface

interface mem_bus_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (
        output en, we, addr, wdata,
        input  rdata
    );

    modport slave (
        input  en, we, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-way round-robin arbiter sharing one fixed-latency memory port between the CPU
// and the loader: one strobe per transaction, then a one-cycle ready with registered data.
module mem_port_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    mem_req_if.slave  cpu,
    mem_req_if.slave  ldr,
    mem_bus_if.master mem,
    output logic      busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int   NREQ     = 2;
    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_LDR  = 1'b1;
    localparam int   CW       = 3;
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY - 1);

    // Requester inputs gathered into owner-indexed vectors
    logic [NREQ-1:0] req_vec;
    logic [NREQ-1:0] we_vec;
    logic [AW-1:0]   addr_vec  [NREQ];
    logic [DW-1:0]   wdata_vec [NREQ];

    assign req_vec               = {ldr.req, cpu.req};
    assign we_vec                = {ldr.we, cpu.we};
    assign addr_vec[OWN_CPU]     = cpu.addr;
    assign addr_vec[OWN_LDR]     = ldr.addr;
    assign wdata_vec[OWN_CPU]    = cpu.wdata;
    assign wdata_vec[OWN_LDR]    = ldr.wdata;

    state_t          state_q,      state_d;
    logic            owner_q,      owner_d;
    logic            last_owner_q, last_owner_d;
    logic            we_q,         we_d;
    logic [CW-1:0]   cnt_q,        cnt_d;
    logic            mem_en_q,     mem_en_d;
    logic            mem_we_q,     mem_we_d;
    logic [AW-1:0]   mem_addr_q,   mem_addr_d;
    logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [NREQ-1:0] ready_q,      ready_d;
    logic [DW-1:0]   rdata_q [NREQ];
    logic [DW-1:0]   rdata_d [NREQ];
    logic            busy_q,       busy_d;
    logic            grant_sel;

    // On a tie the requester that did not win last time gets the port
    assign grant_sel = (req_vec == 2'b11) ? ~last_owner_q : req_vec[OWN_LDR];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ready_d      = '0;
        rdata_d      = rdata_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    owner_d      = grant_sel;
                    last_owner_d = grant_sel;
                    we_d         = we_vec[grant_sel];
                    mem_addr_d   = addr_vec[grant_sel];
                    mem_wdata_d  = wdata_vec[grant_sel];
                    mem_en_d     = 1'b1;
                    mem_we_d     = we_vec[grant_sel];
                    busy_d       = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d[owner_q] = mem.rdata;
                    end
                    ready_d[owner_q] = 1'b1;
                    state_d          = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_LDR;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ready_q      <= '0;
            rdata_q      <= '{default: '0};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign mem.en    = mem_en_q;
    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign cpu.ready = ready_q[OWN_CPU];
    assign cpu.rdata = rdata_q[OWN_CPU];
    assign ldr.ready = ready_q[OWN_LDR];
    assign ldr.rdata = rdata_q[OWN_LDR];
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle table on a latency-1 instance, then hand sequences
// on a latency-3 instance for long latency and mid-transaction reset.
module tb_mem_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_if #(.AW(8), .DW(16)) cpu_a ();
    mem_req_if #(.AW(8), .DW(16)) ldr_a ();
    mem_bus_if #(.AW(8), .DW(16)) mem_a ();
    mem_req_if #(.AW(8), .DW(16)) cpu_b ();
    mem_req_if #(.AW(8), .DW(16)) ldr_b ();
    mem_bus_if #(.AW(8), .DW(16)) mem_b ();
    logic busy_a, busy_b;

    mem_port_arbiter #(.AW(8), .DW(16), .MEM_LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .cpu(cpu_a), .ldr(ldr_a), .mem(mem_a), .busy(busy_a)
    );
    mem_port_arbiter #(.AW(8), .DW(16), .MEM_LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .cpu(cpu_b), .ldr(ldr_b), .mem(mem_b), .busy(busy_b)
    );

    // Memory contents; data is only present on mem_rdata in the exact valid cycle
    function automatic logic [15:0] mem_val(input logic [7:0] a);
        case (a)
            8'h10:   mem_val = 16'hBEEF;
            8'h05:   mem_val = 16'h00A5;
            8'h11:   mem_val = 16'h1111;
            8'h21:   mem_val = 16'h2222;
            default: mem_val = {~a, a};
        endcase
    endfunction

    logic [2:0]  pa_cnt = '0, pb_cnt = '0;
    logic [15:0] pa_dat = '0, pb_dat = '0;
    initial mem_a.rdata = 16'hDEAD;
    initial mem_b.rdata = 16'hDEAD;

    always @(posedge clk) begin
        if (pa_cnt == 3'd1) mem_a.rdata <= pa_dat; else mem_a.rdata <= 16'hDEAD;
        if (pa_cnt != 3'd0) pa_cnt <= pa_cnt - 3'd1;
        if (mem_a.en && !mem_a.we) begin
            if (LAT_A == 1) mem_a.rdata <= mem_val(mem_a.addr);
            else begin pa_cnt <= 3'(LAT_A - 1); pa_dat <= mem_val(mem_a.addr); end
        end
    end

    always @(posedge clk) begin
        if (pb_cnt == 3'd1) mem_b.rdata <= pb_dat; else mem_b.rdata <= 16'hDEAD;
        if (pb_cnt != 3'd0) pb_cnt <= pb_cnt - 3'd1;
        if (mem_b.en && !mem_b.we) begin
            if (LAT_B == 1) mem_b.rdata <= mem_val(mem_b.addr);
            else begin pb_cnt <= 3'(LAT_B - 1); pb_dat <= mem_val(mem_b.addr); end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, " A mem_en"}, 32'(mem_a.en), 0);
        chk({tag, " A mem_we"}, 32'(mem_a.we), 0);
        chk({tag, " A mem_addr"}, 32'(mem_a.addr), 0);
        chk({tag, " A mem_wdata"}, 32'(mem_a.wdata), 0);
        chk({tag, " A cpu_ready"}, 32'(cpu_a.ready), 0);
        chk({tag, " A cpu_rdata"}, 32'(cpu_a.rdata), 0);
        chk({tag, " A ldr_ready"}, 32'(ldr_a.ready), 0);
        chk({tag, " A ldr_rdata"}, 32'(ldr_a.rdata), 0);
        chk({tag, " A busy"}, 32'(busy_a), 0);
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, " B mem_en"}, 32'(mem_b.en), 0);
        chk({tag, " B mem_we"}, 32'(mem_b.we), 0);
        chk({tag, " B mem_addr"}, 32'(mem_b.addr), 0);
        chk({tag, " B mem_wdata"}, 32'(mem_b.wdata), 0);
        chk({tag, " B cpu_ready"}, 32'(cpu_b.ready), 0);
        chk({tag, " B cpu_rdata"}, 32'(cpu_b.rdata), 0);
        chk({tag, " B ldr_ready"}, 32'(ldr_b.ready), 0);
        chk({tag, " B ldr_rdata"}, 32'(ldr_b.rdata), 0);
        chk({tag, " B busy"}, 32'(busy_b), 0);
    endtask

    typedef struct {
        logic        creq, cwe;
        logic [7:0]  caddr;
        logic [15:0] cwd;
        logic        lreq, lwe;
        logic [7:0]  laddr;
        logic [15:0] lwd;
        logic        en, we;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic        crdy;
        logic [15:0] crd;
        logic        lrdy;
        logic [15:0] lrd;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic creq, input logic cwe, input logic [7:0] caddr, input logic [15:0] cwd,
                       input logic lreq, input logic lwe, input logic [7:0] laddr, input logic [15:0] lwd,
                       input logic en, input logic we, input logic [7:0] addr, input logic [15:0] wd,
                       input logic crdy, input logic [15:0] crd, input logic lrdy, input logic [15:0] lrd,
                       input logic busy);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lwd = lwd;
        v.en = en; v.we = we; v.addr = addr; v.wd = wd;
        v.crdy = crdy; v.crd = crd; v.lrdy = lrdy; v.lrd = lrd; v.busy = busy;
        vecs.push_back(v);
    endtask

    initial begin
        int en_count;
        // Row k: inputs before edge k, outputs expected just after edge k
        add(1,0,8'h10,16'h0000, 1,1,8'h20,16'h1234, 1,0,8'h10,16'h0000, 0,16'h0000, 0,16'h0000, 1);
        add(1,0,8'h10,16'h0000, 1,1,8'h20,16'h1234, 0,0,8'h10,16'h0000, 0,16'h0000, 0,16'h0000, 1);
        add(1,0,8'h10,16'h0000, 1,1,8'h20,16'h1234, 0,0,8'h10,16'h0000, 1,16'hBEEF, 0,16'h0000, 1);
        add(1,0,8'h10,16'h0000, 1,1,8'h20,16'h1234, 0,0,8'h10,16'h0000, 0,16'hBEEF, 0,16'h0000, 0);
        add(0,0,8'h10,16'h0000, 1,1,8'h20,16'h1234, 1,1,8'h20,16'h1234, 0,16'hBEEF, 0,16'h0000, 1);
        add(0,0,8'h10,16'h0000, 1,1,8'h20,16'h1234, 0,0,8'h20,16'h1234, 0,16'hBEEF, 0,16'h0000, 1);
        add(0,0,8'h10,16'h0000, 1,1,8'h20,16'h1234, 0,0,8'h20,16'h1234, 0,16'hBEEF, 1,16'h0000, 1);
        add(0,0,8'h10,16'h0000, 1,1,8'h20,16'h1234, 0,0,8'h20,16'h1234, 0,16'hBEEF, 0,16'h0000, 0);
        // Both requesting continuously: four 4-cycle transactions, CPU first
        for (int j = 0; j < 16; j++) begin
            int t, p;
            logic own;
            t = j / 4; p = j % 4; own = t[0];
            add(1,0,8'h11,16'h0000, 1,0,8'h21,16'h5555,
                (p == 0), 0, own ? 8'h21 : 8'h11, own ? 16'h5555 : 16'h0000,
                (p == 2 && !own), (t > 0 || p >= 2) ? 16'h1111 : 16'hBEEF,
                (p == 2 && own), (t > 1 || (t == 1 && p >= 2)) ? 16'h2222 : 16'h0000,
                (p != 3));
        end
        for (int j = 0; j < 2; j++)
            add(0,0,8'h11,16'h0000, 0,0,8'h21,16'h5555, 0,0,8'h21,16'h5555, 0,16'h1111, 0,16'h2222, 0);

        // Reset held with every request high
        cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 8'h10; cpu_a.wdata = 16'h0000;
        ldr_a.req = 1; ldr_a.we = 1; ldr_a.addr = 8'h20; ldr_a.wdata = 16'h1234;
        cpu_b.req = 1; cpu_b.we = 0; cpu_b.addr = 8'h05; cpu_b.wdata = 16'h0000;
        ldr_b.req = 1; ldr_b.we = 0; ldr_b.addr = 8'h30; ldr_b.wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_a("reset");
        chk_zero_b("reset");
        cpu_b.req = 0; ldr_b.req = 0;
        @(negedge clk);
        reset_n = 1;

        en_count = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            cpu_a.req = vecs[i].creq; cpu_a.we = vecs[i].cwe; cpu_a.addr = vecs[i].caddr; cpu_a.wdata = vecs[i].cwd;
            ldr_a.req = vecs[i].lreq; ldr_a.we = vecs[i].lwe; ldr_a.addr = vecs[i].laddr; ldr_a.wdata = vecs[i].lwd;
            @(posedge clk);
            #1;
            if (i >= 8 && mem_a.en === 1'b1) en_count++;
            chk($sformatf("r%0d mem_en", i), 32'(mem_a.en), 32'(vecs[i].en));
            chk($sformatf("r%0d mem_we", i), 32'(mem_a.we), 32'(vecs[i].we));
            chk($sformatf("r%0d mem_addr", i), 32'(mem_a.addr), 32'(vecs[i].addr));
            chk($sformatf("r%0d mem_wdata", i), 32'(mem_a.wdata), 32'(vecs[i].wd));
            chk($sformatf("r%0d cpu_ready", i), 32'(cpu_a.ready), 32'(vecs[i].crdy));
            chk($sformatf("r%0d cpu_rdata", i), 32'(cpu_a.rdata), 32'(vecs[i].crd));
            chk($sformatf("r%0d ldr_ready", i), 32'(ldr_a.ready), 32'(vecs[i].lrdy));
            chk($sformatf("r%0d ldr_rdata", i), 32'(ldr_a.rdata), 32'(vecs[i].lrd));
            chk($sformatf("r%0d busy", i), 32'(busy_a), 32'(vecs[i].busy));
            $display("row %0d: en=%0b addr=%02h crdy=%0b crd=%04h lrdy=%0b lrd=%04h busy=%0b",
                     i, mem_a.en, mem_a.addr, cpu_a.ready, cpu_a.rdata, ldr_a.ready, ldr_a.rdata, busy_a);
        end
        chk("fair mem_en pulses", 32'(en_count), 32'd4);

        // Latency-3 CPU read
        @(negedge clk);
        cpu_b.req = 1; cpu_b.we = 0; cpu_b.addr = 8'h05;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat3 c%0d mem_en", k + 1), 32'(mem_b.en), 32'(k == 0));
            chk($sformatf("lat3 c%0d mem_addr", k + 1), 32'(mem_b.addr), 32'h05);
            chk($sformatf("lat3 c%0d busy", k + 1), 32'(busy_b), 32'(k <= 4));
            chk($sformatf("lat3 c%0d cpu_ready", k + 1), 32'(cpu_b.ready), 32'(k == 4));
            chk($sformatf("lat3 c%0d ldr_ready", k + 1), 32'(ldr_b.ready), 32'd0);
            chk($sformatf("lat3 c%0d cpu_rdata", k + 1), 32'(cpu_b.rdata), (k >= 4) ? 32'h00A5 : 32'h0);
            if (k == 4) cpu_b.req = 0;
        end
        $display("lat3 read done: cpu_rdata=%04h", cpu_b.rdata);

        // Loader read abandoned by reset during WAIT
        @(negedge clk);
        ldr_b.req = 1; ldr_b.we = 0; ldr_b.addr = 8'h30;
        @(posedge clk); #1;
        chk("abort issue mem_en", 32'(mem_b.en), 32'd1);
        chk("abort issue mem_addr", 32'(mem_b.addr), 32'h30);
        @(posedge clk); #1;
        chk("abort wait busy", 32'(busy_b), 32'd1);
        #2;
        reset_n = 0;
        #1;
        chk_zero_a("midreset");
        chk_zero_b("midreset");
        cpu_b.req = 1; cpu_b.we = 0; cpu_b.addr = 8'h05;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("inreset %0d ldr_ready", k), 32'(ldr_b.ready), 32'd0);
            chk($sformatf("inreset %0d busy", k), 32'(busy_b), 32'd0);
        end
        @(negedge clk);
        reset_n = 1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post c%0d mem_en", k + 1), 32'(mem_b.en), 32'(k == 0 || k == 6));
            chk($sformatf("post c%0d mem_addr", k + 1), 32'(mem_b.addr), (k < 6) ? 32'h05 : 32'h30);
            chk($sformatf("post c%0d busy", k + 1), 32'(busy_b), 32'(k <= 4 || (k >= 6 && k <= 10)));
            chk($sformatf("post c%0d cpu_ready", k + 1), 32'(cpu_b.ready), 32'(k == 4));
            chk($sformatf("post c%0d ldr_ready", k + 1), 32'(ldr_b.ready), 32'(k == 10));
            chk($sformatf("post c%0d cpu_rdata", k + 1), 32'(cpu_b.rdata), (k >= 4) ? 32'h00A5 : 32'h0);
            chk($sformatf("post c%0d ldr_rdata", k + 1), 32'(ldr_b.rdata), (k >= 10) ? 32'hCF30 : 32'h0);
            if (k == 4) cpu_b.req = 0;
            if (k == 10) ldr_b.req = 0;
        end
        $display("post-reset: cpu_rdata=%04h ldr_rdata=%04h", cpu_b.rdata, ldr_b.rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
